acc_framer: RTL and testbench
=============================

# acc_framer

Frame controller directly upstream of the DSP48 multiply-accumulator in the holography correlator datapath. It registers the sample stream (din1/din2/din_valid) and generates the macc's new_acc strobe every acc_len valid samples, starting on an external sync after arming. It latches the frame length at each frame start and counts completed frames. On stop it inserts one zero flush sample so the accumulator emits its final frame.

## Interface
- DIN1_WIDTH, 16, width of signed sample 1
- DIN2_WIDTH, 16, width of signed sample 2
- ACC_LEN_WIDTH, 32, width of the frame-length control word
- FRAME_CNT_WIDTH, 32, width of the completed-frame counter

- clk  in  1  single clock for the whole block
- rst_n  in  1  synchronous, active-low reset (sampled on rising clk edge)
- acc_len  in  ACC_LEN_WIDTH  valid samples per frame; 0 treated as 1; sampled at frame start only
- arm  in  1  level/pulse; IDLE→ARMED
- stop  in  1  level/pulse; request end of framing
- sync_in  in  1  external sync pulse; frame alignment
- din1  in  DIN1_WIDTH  signed sample
- din2  in  DIN2_WIDTH  signed sample
- din_valid  in  1  sample qualifier
- dout1  out  DIN1_WIDTH  registered sample to macc
- dout2  out  DIN2_WIDTH  registered sample to macc
- dout_valid  out  1  qualifier to macc din_valid
- new_acc  out  1  first-sample-of-frame strobe to macc new_acc
- frame_cnt  out  FRAME_CNT_WIDTH  completed frames since last arm
- armed  out  1  high in ARMED
- running  out  1  high in RUN and FLUSH

## Operation
- States: IDLE, ARMED, RUN, FLUSH. Reset → IDLE.
- IDLE: dout_valid=0, new_acc=0; input samples discarded. arm=1 → ARMED, clears frame_cnt and sync_seen. stop ignored.
- ARMED: sync_in=1 sets sync_seen. First cycle with din_valid=1 and (sync_in|sync_seen) is sample 0 of frame 0 → RUN. Valid samples before that discarded. stop=1 (priority over sync) → IDLE, no flush.
- RUN: every din_valid=1 sample forwarded with dout_valid=1. Sample index idx counts valid samples; idx==0 → new_acc=1 and len_q latched from acc_len (0→1). When idx==len_q-1 the sample is forwarded, frame_cnt increments (wraps modulo 2^FRAME_CNT_WIDTH), idx→0. arm ignored.
- stop in RUN: latched as stop_pend; takes effect at the next frame boundary (last sample of current frame). If the boundary sample and stop coincide, that boundary is used. Then → FLUSH.
- FLUSH: one cycle, dout1=dout2=0, dout_valid=1, new_acc=1 regardless of din_valid (input discarded), then → IDLE. Flush is not counted in frame_cnt.
- acc_len changes mid-frame have no effect until next frame start.
- sync_in in RUN/FLUSH/IDLE ignored.

## Timing
- Reset values: dout1=0, dout2=0, dout_valid=0, new_acc=0, frame_cnt=0, armed=0, running=0; idx=0, len_q=1, sync_seen=0, stop_pend=0.
- rst_n low mid-frame: immediate return to IDLE on that edge, no flush emitted.
- Latency: 1 cycle din→dout; new_acc aligned with the dout sample it marks; frame_cnt updates on the cycle the boundary sample appears on dout.
- State outputs (armed/running) registered, reflect state after the edge.
- With macc, last frame result appears 2 cycles after macc sees the FLUSH sample.

## Test plan
- acc_len=4, arm, sync_in with continuous valid, 12 samples → new_acc on output samples 0,4,8; frame_cnt 0→1→2→3 after samples 3,7,11.
- acc_len=3, valid toggling 1,0,1,0…: new_acc every 3rd valid sample; invalid cycles give dout_valid=0 and do not advance idx.
- Change acc_len 4→2 at sample 1 of frame 0: frame 0 remains 4 samples, frame 1+ is 2 samples.
- acc_len=5, stop at sample 2 of frame 1: samples 3,4 forwarded, then one FLUSH cycle (0,0,valid=1,new_acc=1), then dout_valid=0, running=0, frame_cnt=2; downstream macc emits frame-1 sum.
- ARMED with sync_in pulsed while din_valid=0, valid arrives 3 cycles later → that sample is frame start; valid samples before sync discarded; stop in ARMED → IDLE with no output.
- acc_len=0 → new_acc on every valid sample; rst_n low mid-frame → all outputs 0 next cycle, no flush.

Source files
------------

// File: rtl/acc_framer_if.sv
// Sample stream between the upstream source, acc_framer and the macc.
// master = upstream side (drives din*), slave = framer side (drives dout* and new_acc).
interface acc_framer_if #(
  parameter int DIN1_WIDTH = 16,
  parameter int DIN2_WIDTH = 16
);
  logic signed [DIN1_WIDTH-1:0] din1;
  logic signed [DIN2_WIDTH-1:0] din2;
  logic                         din_valid;
  logic signed [DIN1_WIDTH-1:0] dout1;
  logic signed [DIN2_WIDTH-1:0] dout2;
  logic                         dout_valid;
  logic                         new_acc;

  modport master (
    output din1, din2, din_valid,
    input  dout1, dout2, dout_valid, new_acc
  );

  modport slave (
    input  din1, din2, din_valid,
    output dout1, dout2, dout_valid, new_acc
  );
endinterface

// File: rtl/acc_framer.sv
// Frame controller ahead of the DSP48 macc: registers the sample stream, strobes
// new_acc every acc_len valid samples after arm+sync, and flushes one zero sample on stop.
module acc_framer #(
  parameter int DIN1_WIDTH      = 16,
  parameter int DIN2_WIDTH      = 16,
  parameter int ACC_LEN_WIDTH   = 32,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  acc_framer_if.slave                bus,
  input  logic [ACC_LEN_WIDTH-1:0]   acc_len,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       sync_in,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       armed,
  output logic                       running
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_FLUSH} state_t;

  localparam logic [ACC_LEN_WIDTH-1:0]   LEN_ONE = ACC_LEN_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE = FRAME_CNT_WIDTH'(1);

  state_t                   state;
  logic [ACC_LEN_WIDTH-1:0] idx;
  logic [ACC_LEN_WIDTH-1:0] len_q;
  logic                     sync_seen;
  logic                     stop_pend;

  logic [ACC_LEN_WIDTH-1:0] start_len;
  logic [ACC_LEN_WIDTH-1:0] cur_len;
  logic                     last_sample;
  logic                     take;

  // At idx 0 the frame length comes straight from acc_len, so a length-1 frame
  // closes on the very sample that opens it.
  // NOTE: every always_comb output gets a value on every path; a missing default infers a latch.
  always_comb begin
    start_len   = (acc_len == '0) ? LEN_ONE : acc_len;
    cur_len     = (idx == '0) ? start_len : len_q;
    last_sample = (idx == cur_len - LEN_ONE);
    take        = bus.din_valid &&
                  ((state == S_RUN) ||
                   ((state == S_ARMED) && !stop && (sync_in || sync_seen)));
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and wins over all other updates.
  // NOTE: all state here uses <=, so every branch sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      len_q         <= LEN_ONE;
      sync_seen     <= 1'b0;
      stop_pend     <= 1'b0;
      frame_cnt     <= '0;
      armed         <= 1'b0;
      running       <= 1'b0;
      bus.dout1     <= '0;
      bus.dout2     <= '0;
      bus.dout_valid <= 1'b0;
      bus.new_acc   <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      bus.new_acc    <= 1'b0;

      if (take) begin
        bus.dout1      <= bus.din1;
        bus.dout2      <= bus.din2;
        bus.dout_valid <= 1'b1;
        bus.new_acc    <= (idx == '0);
        if (idx == '0) len_q <= start_len;
        if (last_sample) begin
          idx       <= '0;
          frame_cnt <= frame_cnt + CNT_ONE;
        end else begin
          idx <= idx + LEN_ONE;
        end
      end

      case (state)
        S_IDLE: begin
          if (arm) begin
            state     <= S_ARMED;
            armed     <= 1'b1;
            frame_cnt <= '0;
            sync_seen <= 1'b0;
            stop_pend <= 1'b0;
            idx       <= '0;
          end
        end
        S_ARMED: begin
          if (stop) begin
            state <= S_IDLE;
            armed <= 1'b0;
          end else if (take) begin
            state   <= S_RUN;
            armed   <= 1'b0;
            running <= 1'b1;
          end else if (sync_in) begin
            sync_seen <= 1'b1;
          end
        end
        S_RUN: begin
          // A stop is held until the frame in flight closes.
          if (take && last_sample && (stop || stop_pend)) begin
            state     <= S_FLUSH;
            stop_pend <= 1'b0;
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        S_FLUSH: begin
          bus.dout1      <= '0;
          bus.dout2      <= '0;
          bus.dout_valid <= 1'b1;
          bus.new_acc    <= 1'b1;
          state          <= S_IDLE;
          running        <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          armed   <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_framer.sv
// Self-checking bench for acc_framer: fixed vector table, directed corner sequences,
// and random stimulus compared each cycle against a frame-level reference model.
module tb_acc_framer;

  localparam int W1 = 16;
  localparam int W2 = 16;
  localparam int LW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] acc_len = '0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          sync_in = 1'b0;
  logic [CW-1:0] frame_cnt;
  logic          armed;
  logic          running;

  acc_framer_if #(.DIN1_WIDTH(W1), .DIN2_WIDTH(W2)) bus ();

  acc_framer #(
    .DIN1_WIDTH(W1), .DIN2_WIDTH(W2), .ACC_LEN_WIDTH(LW), .FRAME_CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .acc_len(acc_len), .arm(arm),
    .stop(stop), .sync_in(sync_in), .frame_cnt(frame_cnt), .armed(armed),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rn, arm, stop, sync, valid;
    logic [15:0] d1, d2;
    logic [31:0] len;
  } in_t;

  typedef struct {
    in_t         i;
    bit          ev, en, ea, er;
    logic [15:0] e1, e2;
    logic [31:0] ef;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tracks the framing session as plain flags and counters.
  bit          m_armed, m_running, m_flush, m_sync, m_stop;
  int unsigned m_pos, m_len;
  bit          e_valid, e_new, e_armed, e_running;
  logic [15:0] e_d1, e_d2;
  logic [31:0] e_frames;

  in_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input bit rn, a, st, sy, v, input logic [15:0] d1, d2,
                             input logic [31:0] len);
    in_t r;
    r.rn = rn; r.arm = a; r.stop = st; r.sync = sy; r.valid = v;
    r.d1 = d1; r.d2 = d2; r.len = len;
    return r;
  endfunction

  function automatic vec_t mv(input in_t i, input bit ev, en, input logic [15:0] e1, e2,
                              input logic [31:0] ef, input bit ea, er);
    vec_t r;
    r.i = i; r.ev = ev; r.en = en; r.e1 = e1; r.e2 = e2; r.ef = ef; r.ea = ea; r.er = er;
    return r;
  endfunction

  task automatic emit(input in_t i, output bit frame_end);
    e_valid = 1'b1;
    e_d1    = i.d1;
    e_d2    = i.d2;
    e_new   = (m_pos == 0);
    if (m_pos == 0) m_len = (i.len == 0) ? 1 : i.len;
    m_pos++;
    frame_end = (m_pos == m_len);
    if (frame_end) begin
      m_pos    = 0;
      e_frames = e_frames + 32'd1;
    end
  endtask

  task automatic model(input in_t i);
    bit fe;
    e_valid = 1'b0;
    e_new   = 1'b0;
    if (!i.rn) begin
      m_armed = 0; m_running = 0; m_flush = 0; m_sync = 0; m_stop = 0;
      m_pos = 0; m_len = 1; e_d1 = '0; e_d2 = '0; e_frames = '0;
    end else if (m_flush) begin
      e_valid = 1'b1; e_new = 1'b1; e_d1 = '0; e_d2 = '0;
      m_flush = 0; m_running = 0; m_stop = 0;
    end else if (m_running) begin
      if (i.stop) m_stop = 1;
      if (i.valid) begin
        emit(i, fe);
        if (fe && m_stop) m_flush = 1;
      end
    end else if (m_armed) begin
      if (i.stop) m_armed = 0;
      else if (i.valid && (i.sync || m_sync)) begin
        m_armed = 0;
        m_running = 1;
        emit(i, fe);
      end else if (i.sync) m_sync = 1;
    end else if (i.arm) begin
      m_armed = 1; m_sync = 0; m_stop = 0; m_pos = 0; e_frames = '0;
    end
    e_armed   = m_armed;
    e_running = m_running;
  endtask

  task automatic check_all();
    check("dout_valid", bus.dout_valid, e_valid);
    check("new_acc", bus.new_acc, e_new);
    if (e_valid) begin
      check("dout1", $unsigned(bus.dout1), e_d1);
      check("dout2", $unsigned(bus.dout2), e_d2);
    end
    check("frame_cnt", frame_cnt, e_frames);
    check("armed", armed, e_armed);
    check("running", running, e_running);
  endtask

  task automatic cycle(input in_t i);
    rst_n = i.rn; arm = i.arm; stop = i.stop; sync_in = i.sync;
    bus.din_valid = i.valid; bus.din1 = i.d1; bus.din2 = i.d2; acc_len = i.len;
    model(i);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic start(input logic [31:0] len);
    cur = mk(0, 0, 0, 0, 0, 16'h0, 16'h0, len);
    cycle(cur);
    cur.rn  = 1;
    cur.arm = 1;
    cycle(cur);
    cur.arm = 0;
  endtask

  vec_t tbl[15];

  initial begin
    logic [15:0] d;
    logic [9:0]  mask;
    int          nv, nn, pos;

    bus.din1 = '0; bus.din2 = '0; bus.din_valid = 1'b0;

    // acc_len=4, arm, sync with continuous valid: 12 samples, 3 frames.
    tbl[0] = mv(mk(0, 0, 0, 0, 0, 16'h0, 16'h0, 4), 0, 0, 16'h0, 16'h0, 0, 0, 0);
    tbl[1] = mv(mk(1, 1, 0, 0, 0, 16'h0, 16'h0, 4), 0, 0, 16'h0, 16'h0, 0, 1, 0);
    for (int k = 0; k < 12; k++) begin
      d = 16'(100 + k);
      tbl[2+k] = mv(mk(1, 0, 0, (k == 0), 1, d, -d, 4),
                    1, (k % 4 == 0), d, -d, 32'((k + 1) / 4), 0, 1);
    end
    tbl[14] = mv(mk(1, 0, 0, 0, 0, 16'h0, 16'h0, 4), 0, 0, 16'h0, 16'h0, 3, 0, 1);

    for (int r = 0; r < 15; r++) begin
      cycle(tbl[r].i);
      check($sformatf("tv%0d_valid", r), bus.dout_valid, tbl[r].ev);
      check($sformatf("tv%0d_new_acc", r), bus.new_acc, tbl[r].en);
      if (tbl[r].ev) begin
        check($sformatf("tv%0d_dout1", r), $unsigned(bus.dout1), tbl[r].e1);
        check($sformatf("tv%0d_dout2", r), $unsigned(bus.dout2), tbl[r].e2);
      end
      check($sformatf("tv%0d_frame_cnt", r), frame_cnt, tbl[r].ef);
      check($sformatf("tv%0d_armed", r), armed, tbl[r].ea);
      check($sformatf("tv%0d_running", r), running, tbl[r].er);
    end

    // acc_len=3 with valid toggling: idle cycles neither forward nor advance idx.
    start(3);
    nv = 0; nn = 0;
    for (int k = 0; k < 12; k++) begin
      cur.valid = (k % 2 == 0); cur.sync = (k == 0);
      cur.d1 = 16'(200 + k); cur.d2 = 16'(k);
      cycle(cur);
      nv += int'(bus.dout_valid);
      nn += int'(bus.new_acc);
    end
    check("a_valid_count", 64'(nv), 64'd6);
    check("a_newacc_count", 64'(nn), 64'd2);
    check("a_frames", frame_cnt, 64'd2);

    // acc_len 4->2 during frame 0: frame 0 stays 4 long, later frames are 2.
    start(4);
    mask = '0; pos = 0;
    for (int k = 0; k < 10; k++) begin
      cur.valid = 1; cur.sync = (k == 0); cur.len = (k >= 1) ? 2 : 4;
      cur.d1 = 16'(300 + k); cur.d2 = 16'(k);
      cycle(cur);
      if (bus.dout_valid) begin
        if (bus.new_acc && pos < 10) mask[pos] = 1'b1;
        pos++;
      end
    end
    check("b_newacc_mask", mask, 10'h151);
    check("b_frames", frame_cnt, 64'd4);

    // acc_len=5, stop at sample 2 of frame 1: finish frame, one flush, idle.
    start(5);
    cur.sync = 0;
    for (int k = 0; k < 10; k++) begin
      cur.valid = 1; cur.sync = (k == 0); cur.stop = (k == 7);
      cur.d1 = 16'(400 + k); cur.d2 = 16'(16'hF000 + k);
      cycle(cur);
    end
    check("c_frames_at_boundary", frame_cnt, 64'd2);
    check("c_running_at_boundary", running, 1'b1);
    cur.stop = 0; cur.d1 = 16'h7777; cur.d2 = 16'h7777;
    cycle(cur);
    check("c_flush_valid", bus.dout_valid, 1'b1);
    check("c_flush_new_acc", bus.new_acc, 1'b1);
    check("c_flush_dout1", $unsigned(bus.dout1), 64'd0);
    check("c_flush_dout2", $unsigned(bus.dout2), 64'd0);
    cycle(cur);
    check("c_after_valid", bus.dout_valid, 1'b0);
    check("c_after_running", running, 1'b0);
    check("c_after_frames", frame_cnt, 64'd2);

    // Valid samples before sync are dropped; sync remembered until valid arrives.
    start(4);
    nv = 0;
    for (int k = 0; k < 2; k++) begin
      cur.valid = 1; cur.d1 = 16'(500 + k);
      cycle(cur);
      nv += int'(bus.dout_valid);
    end
    check("d_presync_dropped", 64'(nv), 64'd0);
    cur.valid = 0; cur.sync = 1;
    cycle(cur);
    cur.sync = 0;
    for (int k = 0; k < 3; k++) cycle(cur);
    check("d_still_armed", armed, 1'b1);
    cur.valid = 1; cur.d1 = 16'h1234; cur.d2 = 16'h4321;
    cycle(cur);
    check("d_start_new_acc", bus.new_acc, 1'b1);
    check("d_start_dout1", $unsigned(bus.dout1), 64'h1234);
    check("d_start_running", running, 1'b1);

    // stop while ARMED returns to IDLE with no output.
    start(4);
    cur.stop = 1; cur.valid = 1; cur.sync = 1;
    cycle(cur);
    check("d_stop_armed", armed, 1'b0);
    check("d_stop_running", running, 1'b0);
    check("d_stop_valid", bus.dout_valid, 1'b0);
    cur.stop = 0;
    cycle(cur);
    check("d_idle_discard", bus.dout_valid, 1'b0);

    // acc_len=0 behaves as 1; then reset in mid-frame gives no flush.
    start(0);
    nn = 0;
    for (int k = 0; k < 5; k++) begin
      cur.valid = 1; cur.sync = (k == 0); cur.d1 = 16'(600 + k);
      cycle(cur);
      nn += int'(bus.new_acc);
    end
    check("e_newacc_every", 64'(nn), 64'd5);
    check("e_frames", frame_cnt, 64'd5);
    cur.len = 3;
    cycle(cur);
    cycle(cur);
    check("e_midframe_frames", frame_cnt, 64'd5);
    cur.rn = 0;
    cycle(cur);
    check("e_rst_valid", bus.dout_valid, 1'b0);
    check("e_rst_new_acc", bus.new_acc, 1'b0);
    check("e_rst_dout1", $unsigned(bus.dout1), 64'd0);
    check("e_rst_frames", frame_cnt, 64'd0);
    check("e_rst_running", running, 1'b0);
    cur.rn = 1;
    cycle(cur);
    check("e_no_flush", bus.dout_valid, 1'b0);

    // Random traffic against the reference model.
    start(3);
    for (int k = 0; k < 3000; k++) begin
      cur.rn    = ($urandom_range(0, 299) != 0);
      cur.arm   = ($urandom_range(0, 5) == 0);
      cur.stop  = ($urandom_range(0, 24) == 0);
      cur.sync  = ($urandom_range(0, 7) == 0);
      cur.valid = ($urandom_range(0, 3) != 0);
      cur.d1    = 16'($urandom);
      cur.d2    = 16'($urandom);
      cur.len   = 32'($urandom_range(0, 6));
      cycle(cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
